neuron_pe: RTL

- Parametrised signed fixed-point neuron processing element, the successor to the single-width neuron accumulator.
- Streams (x, w) pairs over a valid/ready handshake and accumulates the products onto a bias with a saturating accumulator.
- Applies optional ReLU and saturates the result to DATA_W.
- Returns one result per job over a valid/ready output; one instance per neuron in a layer array.

---
 rtl/neuron_pkg.sv | 48 ++++
 rtl/neuron_sat_acc.sv | 57 +++++
 rtl/neuron_pe.sv | 115 +++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared types and saturating arithmetic helpers for the neuron processing element.
// Helpers work on a 64-bit signed carrier so any ACC_W/DATA_W up to 62 bits can reuse them.
package neuron_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int WIDE_W     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    FLUSH = 2'd2,
    OUT   = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [WIDE_W-1:0] val;
    logic                     flag;
  } sat_res_t;

  // Clamp a wide signed value into the two's complement range of a w-bit word.
  function automatic sat_res_t clamp_narrow(input logic signed [WIDE_W-1:0] v, input int w);
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    sat_res_t                 r;
    hi     = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo     = -(64'sd1 <<< (w - 1));
    r.val  = v;
    r.flag = 1'b0;
    if (v > hi) begin
      r.val  = hi;
      r.flag = 1'b1;
    end else if (v < lo) begin
      r.val  = lo;
      r.flag = 1'b1;
    end
    return r;
  endfunction

  // Sum of two w-bit values, clamped to the w-bit range; the carrier never overflows for w <= 62.
  function automatic sat_res_t sat_add(input logic signed [WIDE_W-1:0] a,
                                       input logic signed [WIDE_W-1:0] b,
                                       input int w);
    return clamp_narrow(a + b, w);
  endfunction

endpackage

// File: rtl/neuron_sat_acc.sv
// Product register plus saturating accumulator with a sticky overflow flag.
// One multiply stage ahead of the add: a beat accepted at edge T lands in acc at T+1.
module neuron_sat_acc
  import neuron_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ACC_W-1:0]  load_val,
  input  logic              beat_en,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  output logic [ACC_W-1:0]  acc,
  output logic              sat
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] x_ext;
  logic signed [2*DATA_W-1:0] w_ext;
  logic                       pv;
  sat_res_t                   sum;
  logic [WIDE_W-ACC_W-1:0]    unused_sum_hi;

  assign x_ext = {{DATA_W{x[DATA_W-1]}}, x};
  assign w_ext = {{DATA_W{w[DATA_W-1]}}, w};

  always_comb begin
    sum = sat_add({{(WIDE_W-ACC_W){acc[ACC_W-1]}}, acc},
                  {{(WIDE_W-2*DATA_W){prod[2*DATA_W-1]}}, prod},
                  ACC_W);
  end

  assign unused_sum_hi = sum.val[WIDE_W-1:ACC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0;
      pv   <= 1'b0;
      acc  <= '0;
      sat  <= 1'b0;
    end else begin
      pv <= beat_en;
      if (beat_en) prod <= x_ext * w_ext;
      if (load) begin
        acc <= load_val;
        sat <= 1'b0;
      end else if (pv) begin
        acc <= sum.val[ACC_W-1:0];
        if (sum.flag) sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/neuron_pe.sv
// Fixed-point neuron: bias + sum(x*w) with saturation, optional ReLU, narrowed to DATA_W.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid holds its data until then.
module neuron_pe
  import neuron_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FRAC_W  = FRAC_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_relu,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y,
  output logic              sat,
  output logic [1:0]        dbg_state
);

  state_t                   state;
  state_t                   state_nxt;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         cnt;
  logic [LEN_W-1:0]         cnt_inc;
  logic                     relu_q;
  logic                     load;
  logic                     beat;
  logic [ACC_W-1:0]         load_val;
  logic [ACC_W-1:0]         acc;
  logic                     acc_sat;
  logic signed [WIDE_W-1:0] acc_wide;
  sat_res_t                 narrow;
  logic [WIDE_W-DATA_W-1:0] unused_narrow_hi;

  assign in_ready  = (state == ACC);
  assign beat      = in_valid && in_ready;
  assign load      = (state == IDLE) && start;
  assign cnt_inc   = cnt + LEN_W'(1);
  assign dbg_state = state;
  assign load_val  = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC_W;

  neuron_sat_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_acc (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .beat_en  (beat),
    .x        (x),
    .w        (w),
    .acc      (acc),
    .sat      (acc_sat)
  );

  always_comb begin
    acc_wide = {{(WIDE_W-ACC_W){acc[ACC_W-1]}}, acc};
    narrow   = clamp_narrow(acc_wide >>> FRAC_W, DATA_W);
  end

  assign unused_narrow_hi = narrow.val[WIDE_W-1:DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cfg_len == '0) ? FLUSH : ACC;
      ACC:     if (beat && (cnt_inc == len_q)) state_nxt = FLUSH;
      FLUSH:   state_nxt = OUT;
      OUT:     if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The result is captured one cycle into OUT, once the last product has reached acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      cnt       <= '0;
      relu_q    <= 1'b0;
      y         <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (load) begin
        len_q  <= cfg_len;
        relu_q <= cfg_relu;
        cnt    <= '0;
        sat    <= 1'b0;
      end else if (beat) begin
        cnt <= cnt_inc;
      end
      if ((state == OUT) && !out_valid) begin
        out_valid <= 1'b1;
        sat       <= acc_sat | narrow.flag;
        if (relu_q && narrow.val[DATA_W-1]) y <= '0;
        else                                y <= narrow.val[DATA_W-1:0];
      end else if ((state == OUT) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
